// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch unit.
// Build option: define FETCH_QUEUE2_EN for a two-entry fetch queue (default is one entry).
package fetch_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 16;

`ifdef FETCH_QUEUE2_EN
    localparam int unsigned FETCH_DEPTH = 2;
`else
    localparam int unsigned FETCH_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StFetchLo,
        StFetchHi
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Shift-register instruction queue; slot 0 is always the head.
// Build option: depth follows FETCH_DEPTH, which FETCH_QUEUE2_EN selects.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned Depth = FETCH_DEPTH
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               push_i,
    input  fetch_entry_t                       push_entry_i,
    input  logic                               pop_i,
    input  logic                               flush_i,
    output logic                               valid_o,
    output logic [$clog2(Depth + 1)-1:0]       count_o,
    output fetch_entry_t                       head_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);

    fetch_entry_t [Depth-1:0] mem_q, mem_d;
    logic [CntW-1:0]          count_q, count_d;
    logic [CntW-1:0]          wr_idx;
    logic                     do_push, do_pop;

    // Flush wins over any pop; the fetch FSM never pushes while flushing.
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;
    assign do_push = push_i && !flush_i && ((count_q < CntW'(Depth)) || do_pop);
    assign wr_idx  = count_q - CntW'(do_pop);

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < int'(Depth) - 1; i++) begin
                    mem_d[i] = mem_q[i+1];
                end
            end
            for (int i = 0; i < int'(Depth); i++) begin
                if (do_push && (CntW'(i) == wr_idx)) begin
                    mem_d[i] = push_entry_i;
                end
            end
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    assign head_o  = mem_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Two-beat byte fetch FSM feeding a small instruction queue toward decode.
// Build option: FETCH_QUEUE2_EN selects a two-entry queue instead of one.
module fetch_unit #(
    parameter int unsigned ADDR_W = fetch_pkg::ADDR_W
) (
    input  logic                        CLK,
    input  logic                        RESET_L,
    input  logic [ADDR_W-1:0]           PC,
    input  logic                        EN_L,
    input  logic                        FLUSH,
    output logic                        PC_ADV,
    output logic                        IMEM_REQ,
    output logic [ADDR_W-1:0]           IMEM_ADDR,
    input  logic                        IMEM_ACK,
    input  logic [7:0]                  IMEM_DATA,
    output logic                        INSTR_VALID,
    input  logic                        INSTR_READY,
    output logic [fetch_pkg::INSTR_W-1:0] INSTR,
    output logic [ADDR_W-1:0]           INSTR_PC
);

    import fetch_pkg::*;

    localparam int unsigned CntW = $clog2(FETCH_DEPTH + 1);
    localparam logic [ADDR_W-1:0] EvenMask = ~ADDR_W'(1);

    fetch_state_e          state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [INSTR_W/2-1:0]  lo_byte_q, lo_byte_d;
    logic                  req_q, req_d;
    logic                  kill_q, kill_d;
    logic                  kill;
    logic                  push;
    logic                  pc_adv;
    logic [CntW-1:0]       count;
    fetch_entry_t          head;
    fetch_entry_t          push_entry;

    // A flush seen at any point of a fetch poisons it; the beat still finishes its handshake.
    assign kill = FLUSH || kill_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        lo_byte_d = lo_byte_q;
        req_d     = req_q;
        kill_d    = kill_q;
        push      = 1'b0;
        pc_adv    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!EN_L && !FLUSH && (count < CntW'(FETCH_DEPTH))) begin
                    state_d = StFetchLo;
                    pc_d    = PC & EvenMask;
                    addr_d  = PC & EvenMask;
                    req_d   = 1'b1;
                    kill_d  = 1'b0;
                end
            end
            StFetchLo: begin
                if (IMEM_ACK) begin
                    if (kill) begin
                        state_d = StIdle;
                        req_d   = 1'b0;
                    end else begin
                        state_d   = StFetchHi;
                        lo_byte_d = IMEM_DATA;
                        addr_d    = pc_q | ADDR_W'(1);
                    end
                end else if (FLUSH) begin
                    kill_d = 1'b1;
                end
            end
            StFetchHi: begin
                if (IMEM_ACK) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                    push    = !kill;
                    pc_adv  = !kill;
                end else if (FLUSH) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            addr_q    <= '0;
            lo_byte_q <= '0;
            req_q     <= 1'b0;
            kill_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            lo_byte_q <= lo_byte_d;
            req_q     <= req_d;
            kill_q    <= kill_d;
        end
    end

    assign push_entry = '{instr: {lo_byte_q, IMEM_DATA}, pc: pc_q};

    fetch_queue #(
        .Depth(FETCH_DEPTH)
    ) u_queue (
        .clk_i       (CLK),
        .rst_ni      (RESET_L),
        .push_i      (push),
        .push_entry_i(push_entry),
        .pop_i       (INSTR_READY),
        .flush_i     (FLUSH),
        .valid_o     (INSTR_VALID),
        .count_o     (count),
        .head_o      (head)
    );

    assign PC_ADV    = pc_adv;
    assign IMEM_REQ  = req_q;
    assign IMEM_ADDR = addr_q;
    assign INSTR     = head.instr;
    assign INSTR_PC  = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a behavioural memory and PC-stage model.
// Honours FETCH_QUEUE2_EN through fetch_pkg::FETCH_DEPTH.
module tb_fetch_unit;

    import fetch_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_L;
    logic [7:0]  PC;
    logic        EN_L;
    logic        FLUSH;
    logic        PC_ADV;
    logic        IMEM_REQ;
    logic [7:0]  IMEM_ADDR;
    logic        IMEM_ACK;
    logic [7:0]  IMEM_DATA;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [15:0] INSTR;
    logic [7:0]  INSTR_PC;

    fetch_unit #(
        .ADDR_W(8)
    ) dut (
        .CLK        (CLK),
        .RESET_L    (RESET_L),
        .PC         (PC),
        .EN_L       (EN_L),
        .FLUSH      (FLUSH),
        .PC_ADV     (PC_ADV),
        .IMEM_REQ   (IMEM_REQ),
        .IMEM_ADDR  (IMEM_ADDR),
        .IMEM_ACK   (IMEM_ACK),
        .IMEM_DATA  (IMEM_DATA),
        .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY),
        .INSTR      (INSTR),
        .INSTR_PC   (INSTR_PC)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  pc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ack_addr_q[$];
    logic [7:0] mem [256];
    logic [7:0] pc_model;

    int checks = 0;
    int errors = 0;
    int adv_cnt = 0;
    int wait_cnt = 0;
    int dly_max = 0;
    int dly_fix = 0;
    int ready_pct = 0;
    int flush_pct = 0;
    int en_pct = 0;
    bit flush_force = 1'b0;
    bit spurious = 1'b0;

    logic       prev_req = 1'b0;
    logic       prev_ack = 1'b0;
    logic [7:0] prev_addr = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic int pick_dly();
        return (dly_fix >= 0) ? dly_fix : int'($urandom_range(0, dly_max));
    endfunction

    // One clock: memory responds, PC stage/decode drive, then completed fetches enter the model.
    task automatic cycle();
        logic [7:0] a;
        @(posedge CLK);
        #1;
        if (IMEM_REQ) begin
            if (wait_cnt == 0) begin
                IMEM_ACK  = 1'b1;
                IMEM_DATA = mem[IMEM_ADDR];
                ack_addr_q.push_back(IMEM_ADDR);
                wait_cnt  = pick_dly();
            end else begin
                IMEM_ACK  = 1'b0;
                IMEM_DATA = 8'($urandom);
                wait_cnt--;
            end
        end else begin
            IMEM_ACK  = spurious && ($urandom_range(0, 7) == 0);
            IMEM_DATA = 8'($urandom);
            wait_cnt  = pick_dly();
        end
        #1;
        FLUSH = flush_force || ($urandom_range(0, 99) < flush_pct);
        if (FLUSH) pc_model = 8'($urandom);
        INSTR_READY = ($urandom_range(0, 99) < ready_pct);
        EN_L        = !($urandom_range(0, 99) < en_pct);
        PC          = {pc_model[7:1], 1'($urandom)};
        #1;
        if (PC_ADV && !FLUSH) begin
            a = {pc_model[7:1], 1'b0};
            exp_q.push_back('{instr: {mem[a], mem[a | 8'h01]}, pc: a});
            pc_model = a + 8'h02;
            PC       = {pc_model[7:1], 1'($urandom)};
            adv_cnt++;
        end
    endtask

    task automatic run_until_adv(input int target, input int bound, input string name,
                                 output int n);
        n = 0;
        while (adv_cnt < target && n < bound) begin
            cycle();
            n++;
        end
        chk({name, "_adv_reached"}, adv_cnt, target);
    endtask

    task automatic check_reset(input string p);
        chk({p, "_req"}, IMEM_REQ, 0);
        chk({p, "_addr"}, IMEM_ADDR, 8'h00);
        chk({p, "_pc_adv"}, PC_ADV, 0);
        chk({p, "_valid"}, INSTR_VALID, 0);
        chk({p, "_instr"}, INSTR, 16'h0000);
        chk({p, "_instr_pc"}, INSTR_PC, 8'h00);
    endtask

    // Monitor: pops the scoreboard whenever decode takes the head.
    always @(negedge CLK) begin : monitor
        int   adv_now;
        exp_t e;
        if (!RESET_L) begin
            prev_req = 1'b0;
        end else begin
            adv_now = (PC_ADV && !FLUSH) ? 1 : 0;
            if (FLUSH) chk("pc_adv_on_flush", PC_ADV, 0);
            chk("instr_valid", INSTR_VALID, exp_q.size() > adv_now);
            if (INSTR_VALID && INSTR_READY && !FLUSH && exp_q.size() > adv_now) begin
                e = exp_q.pop_front();
                chk("instr", INSTR, e.instr);
                chk("instr_pc", INSTR_PC, e.pc);
            end
            if (FLUSH) exp_q.delete();
            if (prev_req && !prev_ack) begin
                chk("req_hold", IMEM_REQ, 1);
                chk("addr_hold", IMEM_ADDR, prev_addr);
            end
            if (IMEM_REQ && !prev_req) chk("first_beat_even", IMEM_ADDR[0], 0);
            prev_req  = IMEM_REQ;
            prev_ack  = IMEM_ACK;
            prev_addr = IMEM_ADDR;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int adv0;
        int found;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'hFE]  = 8'hA5;
        mem[8'hFF]  = 8'h3C;
        RESET_L     = 1'b0;
        EN_L        = 1'b1;
        FLUSH       = 1'b0;
        INSTR_READY = 1'b0;
        PC          = 8'h00;
        IMEM_ACK    = 1'b0;
        IMEM_DATA   = 8'h00;
        pc_model    = 8'hFE;
        repeat (3) @(posedge CLK);
        #2;
        check_reset("rst");
        RESET_L = 1'b1;

        // Zero-latency memory, PC=FE: three-cycle fetch of A53C.
        en_pct = 100;
        run_until_adv(1, 20, "t034", n);
        en_pct = 0;
        chk("t034_latency", n, 3);
        chk("t034_beats", ack_addr_q.size(), 2);
        if (ack_addr_q.size() == 2) begin
            chk("t034_addr_lo", ack_addr_q[0], 8'hFE);
            chk("t034_addr_hi", ack_addr_q[1], 8'hFF);
        end
        cycle();
        chk("t034_valid", INSTR_VALID, 1);
        chk("t034_instr", INSTR, 16'hA53C);
        chk("t034_instr_pc", INSTR_PC, 8'hFE);
        repeat (3) cycle();
        chk("t034_single_adv", adv_cnt, 1);
        ready_pct = 100;
        repeat (3) cycle();

        // Odd PC is aligned down to the even byte.
        ack_addr_q.delete();
        pc_model  = 8'h11;
        ready_pct = 0;
        en_pct    = 100;
        dly_fix   = -1;
        dly_max   = 2;
        run_until_adv(adv_cnt + 1, 30, "t035", n);
        en_pct = 0;
        chk("t035_beats", ack_addr_q.size(), 2);
        if (ack_addr_q.size() == 2) begin
            chk("t035_addr_lo", ack_addr_q[0], 8'h10);
            chk("t035_addr_hi", ack_addr_q[1], 8'h11);
        end
        cycle();
        chk("t035_instr_pc", INSTR_PC, 8'h10);
        ready_pct = 100;
        repeat (3) cycle();

        // Decode stalled: queue fills to its depth, then fetch parks.
        spurious  = 1'b1;
        ready_pct = 0;
        en_pct    = 100;
        adv0      = adv_cnt;
        repeat (40) cycle();
        chk("t036_pushes", adv_cnt - adv0, FETCH_DEPTH);
        chk("t036_parked_req", IMEM_REQ, 0);
        chk("t036_valid", INSTR_VALID, 1);
        ready_pct = 100;
        adv0      = adv_cnt;
        repeat (20) cycle();
        chk("t036_resumed", adv_cnt > adv0, 1);
        en_pct = 0;
        repeat (12) cycle();

        // Flush in IDLE holds off the fetch start for that cycle only.
        flush_force = 1'b1;
        en_pct      = 100;
        cycle();
        flush_force = 1'b0;
        cycle();
        chk("t027_blocked", IMEM_REQ, 0);
        cycle();
        chk("t027_started", IMEM_REQ, 1);
        en_pct = 0;
        repeat (10) cycle();

        // Flush while the second beat waits on a slow memory.
        dly_fix = 3;
        en_pct  = 100;
        found   = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            cycle();
            if (IMEM_REQ && IMEM_ADDR[0] && !IMEM_ACK) found = 1;
        end
        chk("t037_found_hi_wait", found, 1);
        adv0        = adv_cnt;
        flush_force = 1'b1;
        en_pct      = 0;
        cycle();
        flush_force = 1'b0;
        chk("t037_req_held", IMEM_REQ, 1);
        cycle();
        chk("t037_empty", INSTR_VALID, 0);
        for (int i = 0; i < 10 && IMEM_REQ; i++) cycle();
        chk("t037_req_dropped", IMEM_REQ, 0);
        chk("t037_no_adv", adv_cnt, adv0);
        cycle();
        chk("t037_still_empty", INSTR_VALID, 0);

        // Random traffic against the scoreboard.
        dly_fix   = -1;
        dly_max   = 3;
        ready_pct = 60;
        flush_pct = 3;
        en_pct    = 80;
        repeat (3000) cycle();
        en_pct    = 0;
        flush_pct = 0;
        ready_pct = 100;
        repeat (30) cycle();
        chk("drain_model_empty", exp_q.size(), 0);
        chk("drain_valid", INSTR_VALID, 0);
        chk("random_progress", adv_cnt > 100, 1);

        // Asynchronous reset in the middle of the first beat.
        dly_fix = 2;
        en_pct  = 100;
        found   = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            cycle();
            if (IMEM_REQ && !IMEM_ADDR[0]) found = 1;
        end
        chk("t039_found_lo", found, 1);
        RESET_L = 1'b0;
        #1;
        check_reset("t039");
        exp_q.delete();
        en_pct = 0;
        repeat (2) cycle();
        check_reset("t039_held");
        RESET_L = 1'b1;
        repeat (5) cycle();
        chk("t039_idle_after", IMEM_REQ, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory byte-address width; the block SHALL support only 8.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RESET_L  in  1  reset, asynchronous, active-low.
REQ-004 PC  in  8  address of next instruction from the PC stage; bit 0 SHALL be ignored.
REQ-005 EN_L  in  1  active-low fetch enable.
REQ-006 FLUSH  in  1  discard queued and in-flight instructions (branch redirect).
REQ-007 PC_ADV  out  1  one-cycle pulse: current PC consumed, PC stage may advance.
REQ-008 IMEM_REQ  out  1  memory read request.
REQ-009 IMEM_ADDR  out  8  memory byte address.
REQ-010 IMEM_ACK  in  1  memory read complete this cycle; IMEM_DATA valid.
REQ-011 IMEM_DATA  in  8  read byte.
REQ-012 INSTR_VALID  out  1  queue head holds an instruction.
REQ-013 INSTR_READY  in  1  decode accepts head this cycle.
REQ-014 INSTR  out  16  head instruction {byte@even, byte@odd}.
REQ-015 INSTR_PC  out  8  even address the head instruction was fetched from.

Function
REQ-016 FSM states SHALL be IDLE, FETCH_LO, FETCH_HI.
REQ-017 IDLE->FETCH_LO when EN_L=0, FLUSH=0, queue count < depth; PC latched as {PC[7:1],0} on that edge.
REQ-018 FETCH_LO: IMEM_REQ=1, IMEM_ADDR=latched PC; on IMEM_ACK capture byte as INSTR[15:8], go FETCH_HI.
REQ-019 FETCH_HI: IMEM_REQ=1, IMEM_ADDR=latched PC|1; on IMEM_ACK push {hi,lo} with latched PC, pulse PC_ADV same cycle, go IDLE.
REQ-020 FETCH_HI SHALL always return to IDLE; minimum 3 cycles per instruction, INSTR_VALID rises the cycle after the FETCH_HI ack.
REQ-021 Once IMEM_REQ is asserted, it and IMEM_ADDR SHALL stay stable until IMEM_ACK; ACK outside a request SHALL be ignored.
REQ-022 EN_L SHALL be evaluated only in IDLE; deassertion mid-fetch does not abort.
REQ-023 Queue pop when INSTR_VALID=1 and INSTR_READY=1; push and pop in the same cycle SHALL both occur.
REQ-024 Push SHALL never meet a full queue (guaranteed by REQ-017).
REQ-025 FLUSH SHALL empty the queue at the next edge; a simultaneous pop is ignored.
REQ-026 FLUSH during FETCH_LO/FETCH_HI: the pending beat completes its handshake, data is discarded, no push, no PC_ADV, FSM goes IDLE.
REQ-027 FLUSH in IDLE SHALL block fetch start that cycle.
REQ-028 When empty, INSTR/INSTR_PC hold the last head slot contents and are don't-care.

Reset
REQ-029 RESET_L=0 SHALL immediately force: state IDLE, queue empty, IMEM_REQ=0, IMEM_ADDR=8'h00, PC_ADV=0, INSTR_VALID=0, INSTR=16'h0000, INSTR_PC=8'h00.
REQ-030 Reset mid-fetch SHALL drop IMEM_REQ without waiting for ACK; memory must tolerate this.

Configuration
REQ-031 FETCH_QUEUE2_EN defined: queue depth 2; undefined: depth 1 (next fetch starts only after head is popped).

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum, ADDR_W, INSTR_W=16 and FETCH_DEPTH (derived from FETCH_QUEUE2_EN).
REQ-033 Queue SHALL be sub-module fetch_queue (push/pop/flush, count, head outputs); FSM stays in fetch_unit.

Verification
REQ-034 Reset release, PC=8'hFE, EN_L=0, ACK same-cycle, memory[FE]=8'hA5, [FF]=8'h3C -> INSTR=16'hA53C, INSTR_PC=8'hFE, one PC_ADV pulse.
REQ-035 PC=8'h11 -> IMEM_ADDR 8'h10 then 8'h11, INSTR_PC=8'h10.
REQ-036 INSTR_READY=0, continuous fetch -> exactly FETCH_DEPTH pushes, FSM parks in IDLE, no IMEM_REQ; raise READY -> fetch resumes.
REQ-037 FLUSH during FETCH_HI with 3-cycle ACK delay -> REQ held until ACK, no push, no PC_ADV, queue empty next cycle.
REQ-038 Push and pop same cycle with one entry queued -> count unchanged, INSTR_VALID stays 1.
REQ-039 RESET_L low during FETCH_LO -> IMEM_REQ=0 before next edge, all outputs at reset values.
